// File: rtl/vx_tcu_drl_fp32sub_pipe.sv
// Pipelined IEEE-754 binary32 subtractor y = a - b (RNE, denormals flushed to zero, tag carried alongside).
// Latency: 3 cycles from input transfer to out_valid; throughput 1 op/cycle.
// Backpressure: stall = out_valid & ~out_ready freezes every stage (bubbles kept); in_ready = ~stall.
// Ports: clk/reset_n (async active-low); in_valid/in_ready/in_a/in_b/in_tag operand side;
//        out_valid/out_ready/out_y/out_tag/out_flags result side, flags = {invalid, overflow, underflow, inexact}.
module vx_tcu_drl_fp32sub_pipe #(
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_y,
  output logic [TAG_W-1:0] out_tag,
  output logic [3:0]       out_flags
);

  logic adv;
  assign adv      = ~(out_valid & ~out_ready);
  assign in_ready = adv;

  // ---------------- S1: unpack, classify, swap, align ----------------
  logic             a_sign, b_sign, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, swap;
  logic [7:0]       a_exp, b_exp, d;
  logic [30:0]      a_mag, b_mag;
  logic [23:0]      a_man, b_man, y_man;
  logic [26:0]      y_ext, y_mask;
  logic             s1_spc_d, s1_inv_d, s1_sign_d, s1_sub_d, s1_zsign_d;
  logic [31:0]      s1_spc_y_d;
  logic [7:0]       s1_exp_d;
  logic [26:0]      s1_x_d, s1_y_d;

  always_comb begin
    a_sign = in_a[31];
    b_sign = ~in_b[31];                    // subtract = add the negated subtrahend
    a_exp  = in_a[30:23];
    b_exp  = in_b[30:23];
    a_zero = (a_exp == 8'h00);
    b_zero = (b_exp == 8'h00);
    a_inf  = (a_exp == 8'hFF) && (in_a[22:0] == 23'd0);
    b_inf  = (b_exp == 8'hFF) && (in_b[22:0] == 23'd0);
    a_nan  = (a_exp == 8'hFF) && (in_a[22:0] != 23'd0);
    b_nan  = (b_exp == 8'hFF) && (in_b[22:0] != 23'd0);
    a_mag  = a_zero ? 31'd0 : in_a[30:0];
    b_mag  = b_zero ? 31'd0 : in_b[30:0];
    a_man  = a_zero ? 24'd0 : {1'b1, in_a[22:0]};
    b_man  = b_zero ? 24'd0 : {1'b1, in_b[22:0]};

    // Specials, in priority order: NaN / inf-inf, then infinity
    s1_spc_d   = a_nan | b_nan | a_inf | b_inf;
    s1_inv_d   = (a_inf & b_inf & (a_sign != b_sign)) |
                 (a_nan & ~in_a[22]) | (b_nan & ~in_b[22]);
    if (a_nan | b_nan | (a_inf & b_inf & (a_sign != b_sign)))
      s1_spc_y_d = 32'h7FC0_0000;
    else
      s1_spc_y_d = {(a_inf ? a_sign : b_sign), 31'h7F80_0000};

    // X holds the larger magnitude so the S2 difference is never negative
    swap      = (b_mag > a_mag);
    s1_sign_d = swap ? b_sign : a_sign;
    s1_exp_d  = swap ? b_exp : a_exp;
    s1_x_d    = {(swap ? b_man : a_man), 3'b000};
    y_man     = swap ? a_man : b_man;
    d         = swap ? (b_exp - a_exp) : (a_exp - b_exp);
    s1_sub_d  = (a_sign != b_sign);
    // An exact zero keeps a negative sign only when both addends are negative
    s1_zsign_d = a_sign & b_sign;

    y_ext  = {y_man, 3'b000};
    y_mask = 27'd0;
    if (d >= 8'd27) begin
      s1_y_d = {26'd0, |y_man};
    end else begin
      y_mask = (27'd1 << d) - 27'd1;
      s1_y_d = y_ext >> d;
      s1_y_d[0] = s1_y_d[0] | (|(y_ext & y_mask));
    end
  end

  logic             s1_vld_q, s1_spc_q, s1_inv_q, s1_sign_q, s1_sub_q, s1_zsign_q;
  logic [TAG_W-1:0] s1_tag_q;
  logic [31:0]      s1_spc_y_q;
  logic [7:0]       s1_exp_q;
  logic [26:0]      s1_x_q, s1_y_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld_q   <= 1'b0;
      s1_tag_q   <= '0;
      s1_spc_q   <= 1'b0;
      s1_inv_q   <= 1'b0;
      s1_spc_y_q <= '0;
      s1_sign_q  <= 1'b0;
      s1_sub_q   <= 1'b0;
      s1_zsign_q <= 1'b0;
      s1_exp_q   <= '0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
    end else if (adv) begin
      s1_vld_q   <= in_valid;
      s1_tag_q   <= in_tag;
      s1_spc_q   <= s1_spc_d;
      s1_inv_q   <= s1_inv_d;
      s1_spc_y_q <= s1_spc_y_d;
      s1_sign_q  <= s1_sign_d;
      s1_sub_q   <= s1_sub_d;
      s1_zsign_q <= s1_zsign_d;
      s1_exp_q   <= s1_exp_d;
      s1_x_q     <= s1_x_d;
      s1_y_q     <= s1_y_d;
    end
  end

  // ---------------- S2: magnitude add / subtract ----------------
  logic [27:0] s2_sum_d;
  assign s2_sum_d = s1_sub_q ? ({1'b0, s1_x_q} - {1'b0, s1_y_q})
                             : ({1'b0, s1_x_q} + {1'b0, s1_y_q});

  logic             s2_vld_q, s2_spc_q, s2_inv_q, s2_sign_q, s2_zsign_q;
  logic [TAG_W-1:0] s2_tag_q;
  logic [31:0]      s2_spc_y_q;
  logic [7:0]       s2_exp_q;
  logic [27:0]      s2_sum_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_vld_q   <= 1'b0;
      s2_tag_q   <= '0;
      s2_spc_q   <= 1'b0;
      s2_inv_q   <= 1'b0;
      s2_spc_y_q <= '0;
      s2_sign_q  <= 1'b0;
      s2_zsign_q <= 1'b0;
      s2_exp_q   <= '0;
      s2_sum_q   <= '0;
    end else if (adv) begin
      s2_vld_q   <= s1_vld_q;
      s2_tag_q   <= s1_tag_q;
      s2_spc_q   <= s1_spc_q;
      s2_inv_q   <= s1_inv_q;
      s2_spc_y_q <= s1_spc_y_q;
      s2_sign_q  <= s1_sign_q;
      s2_zsign_q <= s1_zsign_q;
      s2_exp_q   <= s1_exp_q;
      s2_sum_q   <= s2_sum_d;
    end
  end

  // ---------------- S3: normalise, round, pack ----------------
  logic [4:0]  lz;
  logic [26:0] nm;
  logic [9:0]  e;          // two's complement, so a negative exponent shows in e[9]
  logic [24:0] mr;
  logic [22:0] frac;
  logic        rnd, inx;
  logic [31:0] out_y_d;
  logic [3:0]  out_flags_d;

  always_comb begin
    lz = 5'd0;
    for (int i = 0; i < 27; i++)
      if (s2_sum_q[i]) lz = 5'(26 - i);

    if (s2_sum_q[27]) begin
      nm = {s2_sum_q[27:2], s2_sum_q[1] | s2_sum_q[0]};
      e  = {2'b00, s2_exp_q} + 10'd1;
    end else begin
      nm = s2_sum_q[26:0] << lz;
      e  = {2'b00, s2_exp_q} - {5'd0, lz};
    end

    inx = |nm[2:0];
    rnd = nm[2] & (nm[1] | nm[0] | nm[3]);
    mr  = {1'b0, nm[26:3]} + {24'd0, rnd};
    if (mr[24]) begin
      e    = e + 10'd1;
      frac = mr[23:1];
    end else begin
      frac = mr[22:0];
    end

    out_y_d     = '0;
    out_flags_d = '0;
    if (s2_spc_q) begin
      out_y_d     = s2_spc_y_q;
      out_flags_d = {s2_inv_q, 3'b000};
    end else if (s2_sum_q == 28'd0) begin
      out_y_d = {s2_zsign_q, 31'd0};
    end else if (!e[9] && (e >= 10'd255)) begin
      out_y_d     = {s2_sign_q, 31'h7F80_0000};
      out_flags_d = 4'b0101;
    end else if (e[9] || (e == 10'd0)) begin
      out_y_d     = {s2_sign_q, 31'd0};
      out_flags_d = 4'b0011;
    end else begin
      out_y_d     = {s2_sign_q, e[7:0], frac};
      out_flags_d = {3'b000, inx};
    end
  end

  logic             out_valid_q;
  logic [TAG_W-1:0] out_tag_q;
  logic [31:0]      out_y_q;
  logic [3:0]       out_flags_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_tag_q   <= '0;
      out_y_q     <= '0;
      out_flags_q <= '0;
    end else if (adv) begin
      out_valid_q <= s2_vld_q;
      out_tag_q   <= s2_tag_q;
      out_y_q     <= out_y_d;
      out_flags_q <= out_flags_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_tag   = out_tag_q;
  assign out_y     = out_y_q;
  assign out_flags = out_flags_q;

endmodule

// File: tb/tb_vx_tcu_drl_fp32sub_pipe.sv
// Directed-vector bench for the fp32 subtract pipe with a queue scoreboard.
// Stimulus pushes the hand-computed result on transfer; a negedge monitor pops and compares.
// out_ready is either held high or toggled 1,0,0 to exercise stalls.
module tb_vx_tcu_drl_fp32sub_pipe;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [7:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_y;
  logic [7:0]  out_tag;
  logic [3:0]  out_flags;

  vx_tcu_drl_fp32sub_pipe #(.TAG_W(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_tag(out_tag),
    .out_flags(out_flags)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] y;
    logic [3:0]  f;
    logic [7:0]  tag;
    bit          chk_lat;
    int          icyc;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   toggle_en = 1'b0;
  int   tidx = 0;

  logic [31:0] fl [0:11] = '{32'h0000_0000, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000,
                             32'h4080_0000, 32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000,
                             32'h4100_0000, 32'h4110_0000, 32'h4120_0000, 32'h4130_0000};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // out_ready pattern 1,0,0 repeating while toggling, else held high
  always @(posedge clk) begin
    #1;
    if (toggle_en) begin
      out_ready = (tidx == 0);
      tidx = (tidx == 2) ? 0 : tidx + 1;
    end else begin
      out_ready = 1'b1;
      tidx = 0;
    end
  end

  // Monitor: handshake rule every cycle, result comparison on each output transfer
  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      check("in_ready", {31'd0, in_ready}, {31'd0, !(out_valid && !out_ready)});
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_output: got tag %0h y %0h, required no output", out_tag, out_y);
        end else begin
          e = sbq.pop_front();
          check($sformatf("y[tag %0h]", e.tag), out_y, e.y);
          check($sformatf("flags[tag %0h]", e.tag), {28'd0, out_flags}, {28'd0, e.f});
          check($sformatf("tag[tag %0h]", e.tag), {24'd0, out_tag}, {24'd0, e.tag});
          if (e.chk_lat)
            check($sformatf("latency[tag %0h]", e.tag), 32'(cyc - e.icyc), 32'd3);
        end
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [7:0] tag,
                      input logic [31:0] y, input logic [3:0] f, input bit lat);
    int   w;
    exp_t e;
    in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout[tag %0h]: in_ready got 0 required 1", tag);
      @(posedge clk);
      #1 in_valid = 1'b0;
    end else begin
      e.y = y; e.f = f; e.tag = tag; e.chk_lat = lat; e.icyc = cyc;
      @(posedge clk);
      sbq.push_back(e);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sbq.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (sbq.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: pending got %0d required 0", sbq.size());
      sbq.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_y", out_y, 32'd0);
    check("rst_out_tag", {24'd0, out_tag}, 32'd0);
    check("rst_out_flags", {28'd0, out_flags}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // 3.0 - 1.0 alone, with latency
    send(32'h4040_0000, 32'h3F80_0000, 8'h01, 32'h4000_0000, 4'b0000, 1'b1);
    drain();

    // Directed boundary vectors, back to back
    send(32'h3F80_0000, 32'h3F80_0000, 8'h10, 32'h0000_0000, 4'b0000, 1'b0); // 1-1 = +0
    send(32'h8000_0000, 32'h0000_0000, 8'h11, 32'h8000_0000, 4'b0000, 1'b0); // -0 - +0 = -0
    send(32'h3F80_0000, 32'h3380_0000, 8'h12, 32'h3F7F_FFFF, 4'b0000, 1'b0); // 1 - 2^-24 exact
    send(32'h3F80_0000, 32'hB380_0000, 8'h13, 32'h3F80_0000, 4'b0001, 1'b0); // tie to even
    send(32'h3F80_0000, 32'hB3C0_0000, 8'h14, 32'h3F80_0001, 4'b0001, 1'b0); // above half, rounds up
    send(32'h7F80_0000, 32'h7F80_0000, 8'h15, 32'h7FC0_0000, 4'b1000, 1'b0); // inf - inf
    send(32'h7F7F_FFFF, 32'hFF7F_FFFF, 8'h16, 32'h7F80_0000, 4'b0101, 1'b0); // overflow
    send(32'h7F80_0001, 32'h3F80_0000, 8'h17, 32'h7FC0_0000, 4'b1000, 1'b0); // sNaN
    send(32'h7FC0_0000, 32'h3F80_0000, 8'h18, 32'h7FC0_0000, 4'b0000, 1'b0); // qNaN
    send(32'h7F80_0000, 32'h3F80_0000, 8'h19, 32'h7F80_0000, 4'b0000, 1'b0); // inf - 1
    send(32'h3F80_0000, 32'h7F80_0000, 8'h1A, 32'hFF80_0000, 4'b0000, 1'b0); // 1 - inf
    send(32'h0000_0001, 32'h0000_0000, 8'h1B, 32'h0000_0000, 4'b0000, 1'b0); // denormal in -> +0
    send(32'h0080_0000, 32'h00C0_0000, 8'h1C, 32'h8000_0000, 4'b0011, 1'b0); // denormal out -> -0
    drain();

    // Stream of 10 ops under a 1,0,0 out_ready pattern: (i+2) - 1 = i+1
    toggle_en = 1'b1;
    for (int i = 0; i < 10; i++)
      send(fl[i+2], fl[1], 8'(i), fl[i+1], 4'b0000, 1'b0);
    drain();
    toggle_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset with three ops in flight
    send(fl[5], fl[1], 8'h30, fl[4], 4'b0000, 1'b0);
    send(fl[6], fl[1], 8'h31, fl[5], 4'b0000, 1'b0);
    send(fl[7], fl[1], 8'h32, fl[6], 4'b0000, 1'b0);
    reset_n = 1'b0;
    sbq.delete();
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_out_tag", {24'd0, out_tag}, 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    send(fl[11], fl[1], 8'h5A, fl[10], 4'b0000, 1'b1);
    drain();
    repeat (5) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
